// File: rtl/timer_pkg.sv
// Shared encodings for the interval timer: FSM states, mode values and counter slice width.
package timer_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int SLICE_W = 4;
endpackage

// File: rtl/count4_slice.sv
// 4-bit synchronous-load up-counter slice with count enable (ENT) and ripple carry out (RCO).
module count4_slice
    import timer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               ent,
    input  logic [SLICE_W-1:0] d,
    output logic [SLICE_W-1:0] q,
    output logic               rco
);
    logic [SLICE_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load)
            q_d = d;
        else if (ent)
            q_d = q_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q   = q_q;
    assign rco = ent & (&q_q);
endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer: one-shot / periodic up-counter from a preset to all-ones, built from chained 4-bit slices.
// Optional prescaler on the count enable when TIMER_PRESCALE_EN is defined.
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] preset,
`ifdef TIMER_PRESCALE_EN
    input  logic [3:0]       psc,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tick
);
    localparam int NSL = WIDTH / SLICE_W;

    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic             tick_q, tick_d;

    logic             en;
    logic             tc;
    logic [NSL:0]     carry;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_din;

`ifdef TIMER_PRESCALE_EN
    logic [3:0] psc_q, psc_d;

    always_comb begin
        psc_d = '0;
        en    = 1'b0;
        if (state_q == ST_RUN && !stop) begin
            if (psc_q == psc)
                en = 1'b1;
            else
                psc_d = psc_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            psc_q <= '0;
        else
            psc_q <= psc_d;
    end
`else
    assign en = (state_q == ST_RUN) && !stop;
`endif

    // Terminal count is the carry out of the top slice: enabled and every bit set.
    assign carry[0] = en;
    assign tc       = carry[NSL];

    // One-shot terminal count reloads the current all-ones value so the counter cannot wrap.
    assign cnt_load = (state_q == ST_LOAD && !stop) || tc;
    assign cnt_din  = (tc && mode_q == MODE_ONESHOT) ? count : preset_q;

    for (genvar i = 0; i < NSL; i++) begin : g_slice
        count4_slice u_slice (
            .clk  (clk),
            .rst  (rst),
            .load (cnt_load),
            .ent  (carry[i]),
            .d    (cnt_din[i*SLICE_W +: SLICE_W]),
            .q    (count[i*SLICE_W +: SLICE_W]),
            .rco  (carry[i+1])
        );
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        preset_d = preset_q;
        tick_d   = tc;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stop)
                    state_d = ST_IDLE;
                else if (start) begin
                    state_d  = ST_LOAD;
                    mode_d   = mode;
                    preset_d = preset;
                end
            end
            ST_LOAD: state_d = stop ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (stop)
                    state_d = ST_IDLE;
                else if (tc && mode_q == MODE_ONESHOT)
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_ONESHOT;
            preset_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            preset_q <= preset_d;
            tick_q   <= tick_d;
        end
    end

    assign busy = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign tick = tick_q;
endmodule

// File: doc/interval_timer_ctrl.md
INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, counter width in bits; SHALL be 8, 16 or 32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin timing; sampled only in IDLE or DONE.
REQ-005 stop  input  1  abort request; sampled in LOAD, RUN, DONE.
REQ-006 mode  input  1  0 = one-shot, 1 = periodic (auto-reload); latched on accepted start.
REQ-007 preset  input  WIDTH  start value for the up-count; latched on accepted start.
REQ-008 count  output  WIDTH  current counter value.
REQ-009 busy  output  1  high in LOAD and RUN.
REQ-010 done  output  1  high in DONE.
REQ-011 tick  output  1  one-cycle terminal-count pulse.

Function
REQ-012 FSM SHALL have states IDLE, LOAD, RUN, DONE.
REQ-013 IDLE/DONE with start=1, stop=0 -> LOAD next cycle; mode and preset latched at that edge.
REQ-014 LOAD lasts exactly one cycle; at its closing edge count <= latched preset and state -> RUN.
REQ-015 In RUN, count SHALL increment by 1 on each enabled cycle (every cycle when prescaler is absent).
REQ-016 Terminal count = RUN, enabled, count all-ones; at that edge tick <= 1 for the following cycle only.
REQ-017 One-shot at terminal count: state -> DONE, count holds all-ones (no wrap to zero).
REQ-018 Periodic at terminal count: count <= latched preset, state stays RUN; count never reads zero via wrap unless preset = 0.
REQ-019 preset = all-ones: terminal count occurs on first enabled RUN cycle.
REQ-020 stop=1 in LOAD or RUN -> IDLE next cycle, count holds, no tick; stop in DONE -> IDLE.
REQ-021 start and stop both high: stop wins; start ignored.
REQ-022 start while busy SHALL be ignored; preset/mode changes while busy have no effect.
REQ-023 Counter SHALL be built from WIDTH/4 chained 4-bit slices; slice i enable = ripple-carry of slice i-1 (slice 0 enable = global enable).

Reset
REQ-024 rst asserted SHALL immediately force state IDLE, count 0, tick 0, busy 0, done 0, latched mode/preset 0, prescaler 0.
REQ-025 rst mid-RUN SHALL abort with no tick emitted; operation resumes only on a new start after rst release.

Configuration
REQ-026 Macro TIMER_PRESCALE_EN defined: extra input psc [3:0]; global enable asserted once per psc+1 RUN cycles; prescaler cleared in LOAD and on stop.
REQ-027 Macro TIMER_PRESCALE_EN undefined: no psc port, global enable = 1 in RUN, no prescaler logic.

Structure
REQ-028 Shared package timer_pkg SHALL hold the state encoding, mode encoding constants and the slice width constant (4).
REQ-029 One sub-module count4_slice (4-bit synchronous-load up-counter, ENT in, RCO out, LOAD in) SHALL be instantiated WIDTH/4 times via generate.

Verification
REQ-030 WIDTH=8, one-shot, preset=8'hFC, start pulse at cycle 0 -> LOAD cycle 1, count FC,FD,FE,FF in cycles 2-5, tick=1 and done=1 in cycle 6, count stays FF.
REQ-031 WIDTH=8, periodic, preset=8'hFE -> tick every 2 RUN cycles, count sequence FE,FF,FE,FF..., busy stays 1.
REQ-032 WIDTH=16, one-shot, preset=16'h00FF -> carry ripples: count 00FF -> 0100 in one cycle; tick after 65281 RUN cycles.
REQ-033 stop and start asserted together in IDLE -> stays IDLE; stop during RUN at count 8'h10 -> IDLE, count holds 10, no tick.
REQ-034 rst asserted mid-cycle during RUN (async) -> count 0, busy 0 before next clock edge; no tick.
REQ-035 TIMER_PRESCALE_EN defined, psc=3, preset=8'hFE, one-shot -> count advances every 4 cycles; tick 8 cycles after RUN entry.
